// File: rtl/uart_rx_ram_loader.sv
// uart_rx_ram_loader: 8N1 UART receiver that fills a DEPTH x 8 RAM from address 0 upward.
// Ports: clk, rst_n, rs232_rx, clr in; wr_en/addr/data, rx_done, frame_err, overflow, full, byte_cnt out.
module uart_rx_ram_loader #(
  parameter int CLK_FREQ = 50_000_000,
  parameter int BAUD     = 9600,
  parameter int BPS_DIV  = CLK_FREQ / BAUD,
  parameter int DEPTH    = 256
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rs232_rx,
  input  logic       clr,
  output logic       wr_en,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data,
  output logic       rx_done,
  output logic       frame_err,
  output logic       overflow,
  output logic       full,
  output logic [8:0] byte_cnt
);

  localparam int CW = (BPS_DIV > 2) ? $clog2(BPS_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(BPS_DIV - 1);
  localparam logic [CW-1:0] HALF = CW'(BPS_DIV / 2 - 1);
  localparam logic [7:0] LAST_ADDR = 8'(DEPTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  state_t        r_state;
  logic          r_sync1;
  logic          r_sync2;
  logic          r_prev;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_bit;
  logic [7:0]    r_shift;
  logic          r_wr_en;
  logic [7:0]    r_wr_data;
  logic          r_rx_done;
  logic          r_frame_err;
  logic          r_overflow;
  logic [7:0]    r_addr;
  logic [8:0]    r_byte_cnt;
  logic          r_full;

  logic w_rx;
  logic w_fall;
  logic w_full;

  assign w_rx   = r_sync2;
  assign w_fall = r_prev & ~r_sync2;
  // A clr landing on the stop-sample edge empties the RAM first.
  assign w_full = r_full & ~clr;

  // Two-flop synchronizer plus one flop of history for edge detect.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_prev  <= 1'b1;
    end else begin
      r_sync1 <= rs232_rx;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

  // Receive FSM with registered write/status pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_bit       <= '0;
      r_shift     <= '0;
      r_wr_en     <= 1'b0;
      r_wr_data   <= '0;
      r_rx_done   <= 1'b0;
      r_frame_err <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      r_wr_en     <= 1'b0;
      r_rx_done   <= 1'b0;
      r_frame_err <= 1'b0;
      r_overflow  <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          r_cnt <= '0;
          if (w_fall) r_state <= S_START;
        end
        S_START: begin
          if (r_cnt == HALF) begin
            r_cnt <= '0;
            if (w_rx) begin
              r_state <= S_IDLE;
            end else begin
              r_state <= S_DATA;
              r_bit   <= '0;
            end
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_DATA: begin
          if (r_cnt == LAST) begin
            r_cnt   <= '0;
            r_shift <= {w_rx, r_shift[7:1]};
            r_bit   <= r_bit + 3'd1;
            if (r_bit == 3'd7) r_state <= S_STOP;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_STOP: begin
          // Leave at mid stop bit so a back-to-back start edge is caught.
          if (r_cnt == LAST) begin
            r_cnt   <= '0;
            r_state <= S_IDLE;
            if (w_rx) begin
              r_rx_done <= 1'b1;
              if (w_full) begin
                r_overflow <= 1'b1;
              end else begin
                r_wr_en   <= 1'b1;
                r_wr_data <= r_shift;
              end
            end else begin
              r_frame_err <= 1'b1;
            end
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Address / count bookkeeping; clr wins over a concurrent write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr     <= '0;
      r_byte_cnt <= '0;
      r_full     <= 1'b0;
    end else if (clr) begin
      r_addr     <= '0;
      r_byte_cnt <= '0;
      r_full     <= 1'b0;
    end else if (r_wr_en) begin
      r_byte_cnt <= r_byte_cnt + 9'd1;
      if (r_addr == LAST_ADDR) r_full <= 1'b1;
      else r_addr <= r_addr + 8'd1;
    end
  end

  assign wr_en     = r_wr_en;
  assign wr_addr   = r_addr;
  assign wr_data   = r_wr_data;
  assign rx_done   = r_rx_done;
  assign frame_err = r_frame_err;
  assign overflow  = r_overflow;
  assign full      = r_full;
  assign byte_cnt  = r_byte_cnt;

endmodule

// File: tb/tb_uart_rx_ram_loader.sv
// tb_uart_rx_ram_loader: directed, table-driven bench for uart_rx_ram_loader.
// Drives 8N1 frames at BPS_DIV=16 and checks writes, status pulses and counters.
module tb_uart_rx_ram_loader;

  localparam int BPS = 16;

  logic       clk;
  logic       rst_n;
  logic       rs232_rx;
  logic       clr;
  logic       wr_en;
  logic [7:0] wr_addr;
  logic [7:0] wr_data;
  logic       rx_done;
  logic       frame_err;
  logic       overflow;
  logic       full;
  logic [8:0] byte_cnt;

  uart_rx_ram_loader #(.BPS_DIV(BPS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rs232_rx  (rs232_rx),
    .clr       (clr),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .rx_done   (rx_done),
    .frame_err (frame_err),
    .overflow  (overflow),
    .full      (full),
    .byte_cnt  (byte_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;
  int n_wr = 0;
  int n_rxd = 0;
  int n_fe = 0;
  int n_ov = 0;
  int last_addr = -1;
  int last_data = -1;
  logic [7:0] mem [256];

  // Passive event log sampled away from the active edge.
  always @(negedge clk) begin
    if (wr_en) begin
      n_wr++;
      last_addr = int'(wr_addr);
      last_data = int'(wr_data);
      mem[wr_addr] = wr_data;
    end
    if (rx_done) n_rxd++;
    if (frame_err) n_fe++;
    if (overflow) n_ov++;
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d want %0d", nm, act, exp);
  endtask

  task automatic hold(input logic v, input int cycles);
    rs232_rx = v;
    repeat (cycles) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] d, input logic stop);
    hold(1'b0, BPS);
    for (int i = 0; i < 8; i++) hold(d[i], BPS);
    hold(stop, BPS);
    // A low stop bit needs the line back high before the next start edge.
    if (!stop) hold(1'b1, BPS);
    rs232_rx = 1'b1;
  endtask

  task automatic pulse_clr();
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
  endtask

  typedef struct {
    logic [7:0] d;
    logic       stop;
    logic       pre_clr;
    int         wr;
    int         addr;
    int         fe;
    int         cnt;
  } vec_t;

  vec_t vt [6];

  initial begin
    int w0, r0, f0, o0, bad;
    vt[0] = '{8'hA5, 1'b1, 1'b0, 1, 0, 0, 1};
    vt[1] = '{8'h00, 1'b1, 1'b1, 1, 0, 0, 1};
    vt[2] = '{8'hFF, 1'b1, 1'b0, 1, 1, 0, 2};
    vt[3] = '{8'h3C, 1'b1, 1'b0, 1, 2, 0, 3};
    vt[4] = '{8'h55, 1'b0, 1'b0, 0, 0, 1, 3};
    vt[5] = '{8'h12, 1'b1, 1'b0, 1, 3, 0, 4};

    rst_n = 1'b0;
    rs232_rx = 1'b1;
    clr = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    chk("reset_wr_en", int'(wr_en), 0);
    chk("reset_addr", int'(wr_addr), 0);
    chk("reset_data", int'(wr_data), 0);
    chk("reset_status", int'({rx_done, frame_err, overflow, full}), 0);
    chk("reset_cnt", int'(byte_cnt), 0);

    // Table: single byte, back-to-back run, frame error, recovery.
    for (int i = 0; i < 6; i++) begin
      if (vt[i].pre_clr) pulse_clr();
      w0 = n_wr; r0 = n_rxd; f0 = n_fe;
      send(vt[i].d, vt[i].stop);
      chk($sformatf("v%0d_wr", i), n_wr - w0, vt[i].wr);
      chk($sformatf("v%0d_rxd", i), n_rxd - r0, vt[i].wr);
      chk($sformatf("v%0d_fe", i), n_fe - f0, vt[i].fe);
      chk($sformatf("v%0d_cnt", i), int'(byte_cnt), vt[i].cnt);
      if (vt[i].wr != 0) begin
        chk($sformatf("v%0d_addr", i), last_addr, vt[i].addr);
        chk($sformatf("v%0d_data", i), last_data, int'(vt[i].d));
      end
    end

    // Short low glitch must be rejected silently.
    w0 = n_wr; r0 = n_rxd; f0 = n_fe;
    hold(1'b0, 5);
    hold(1'b1, 3 * BPS);
    chk("glitch_wr", n_wr - w0, 0);
    chk("glitch_rxd", n_rxd - r0, 0);
    chk("glitch_fe", n_fe - f0, 0);
    send(8'h66, 1'b1);
    chk("post_glitch_addr", last_addr, 4);
    chk("post_glitch_data", last_data, 8'h66);

    // Break: one frame error, no restart while low.
    w0 = n_wr; f0 = n_fe;
    hold(1'b0, 40 * BPS);
    hold(1'b1, 2 * BPS);
    chk("break_fe", n_fe - f0, 1);
    chk("break_wr", n_wr - w0, 0);

    // Fill all 256 words.
    pulse_clr();
    chk("clr_cnt", int'(byte_cnt), 0);
    for (int i = 0; i < 255; i++) send(8'(i), 1'b1);
    chk("full_before_last", int'(full), 0);
    send(8'hFF, 1'b1);
    bad = 0;
    for (int i = 0; i < 256; i++) if (mem[i] != 8'(i)) bad++;
    chk("fill_bad_words", bad, 0);
    chk("fill_full", int'(full), 1);
    chk("fill_cnt", int'(byte_cnt), 256);
    chk("fill_addr_sat", int'(wr_addr), 255);

    w0 = n_wr; r0 = n_rxd; o0 = n_ov;
    send(8'h77, 1'b1);
    chk("ovf_wr", n_wr - w0, 0);
    chk("ovf_rxd", n_rxd - r0, 1);
    chk("ovf_ov", n_ov - o0, 1);
    chk("ovf_cnt", int'(byte_cnt), 256);

    pulse_clr();
    chk("clr_full", int'(full), 0);
    chk("clr_cnt2", int'(byte_cnt), 0);
    send(8'h5A, 1'b1);
    chk("after_clr_addr", last_addr, 0);
    chk("after_clr_data", last_data, 8'h5A);

    // Reset during bit 4 of a frame.
    w0 = n_wr;
    hold(1'b0, BPS);
    for (int i = 0; i < 4; i++) hold(1'(8'h81 >> i), BPS);
    hold(1'b0, BPS / 2);
    rst_n = 1'b0;
    rs232_rx = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_mid_cnt", int'(byte_cnt), 0);
    chk("rst_mid_data", int'(wr_data), 0);
    chk("rst_mid_flags", int'({wr_en, rx_done, frame_err, overflow, full}), 0);
    rst_n = 1'b1;
    hold(1'b1, 2 * BPS);
    chk("rst_mid_nowr", n_wr - w0, 0);
    send(8'h81, 1'b1);
    chk("rst_after_addr", last_addr, 0);
    chk("rst_after_data", last_data, 8'h81);
    chk("rst_after_cnt", int'(byte_cnt), 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
